// File: rtl/dram_access_arbiter.sv
// Two-port arbiter for the single-port data RAM: port 0 is the CPU MEM stage, port 1 the
// context save/restore engine. Round-robin on ties, fixed-delay access timer, one-cycle response.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and latch the winner's request
// ACCESS | RAM selected; timer counts CLK_DELAY cycles, read data captured at terminal count
// RESP   | one-cycle ack/rdata/err pulse to the granted port
module dram_access_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int CLK_DELAY  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(CLK_DELAY - 1);

  state_t      state;
  logic        rr_last;
  logic        gnt_port;
  logic        we_r;
  logic [3:0]  cnt;

  logic        pick_valid;
  logic        pick_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_in_range;
  logic [31:0] read_word;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    pick_valid = m0_req | m1_req;
    pick_port  = 1'b0;
    if (m0_req && m1_req)
      pick_port = ~rr_last;
    else if (m1_req)
      pick_port = 1'b1;
  end

  assign sel_we       = pick_port ? m1_we    : m0_we;
  assign sel_addr     = pick_port ? m1_addr  : m0_addr;
  assign sel_wdata    = pick_port ? m1_wdata : m0_wdata;
  assign sel_in_range = (sel_addr >> ADDR_WIDTH) == 32'd0;
  assign read_word    = we_r ? 32'd0 : mem_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      gnt_port <= 1'b0;
      we_r     <= 1'b0;
      cnt      <= 4'd0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 32'd0;
      mem_din  <= 32'd0;
      m0_ack   <= 1'b0;
      m0_rdata <= 32'd0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_rdata <= 32'd0;
      m1_err   <= 1'b0;
    end else begin
      // Response outputs and the write strobe are single-cycle pulses.
      m0_ack   <= 1'b0;
      m0_rdata <= 32'd0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_rdata <= 32'd0;
      m1_err   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_port <= pick_port;
            rr_last  <= pick_port;
            we_r     <= sel_we;
            if (sel_in_range) begin
              cnt      <= CNT_INIT;
              mem_cs   <= 1'b1;
              mem_we   <= sel_we;
              mem_addr <= sel_addr;
              mem_din  <= sel_wdata;
              state    <= ACCESS;
            end else begin
              // Out-of-range requests never reach the RAM.
              if (pick_port) begin
                m1_ack <= 1'b1;
                m1_err <= 1'b1;
              end else begin
                m0_ack <= 1'b1;
                m0_err <= 1'b1;
              end
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_cs   <= 1'b0;
            mem_addr <= 32'd0;
            mem_din  <= 32'd0;
            if (gnt_port) begin
              m1_ack   <= 1'b1;
              m1_rdata <= read_word;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= read_word;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          mem_cs <= 1'b0;
        end
      endcase
    end
  end

  // Reset gating keeps the pipeline unstalled while the arbiter is held in reset.
  assign stall = rst & m0_req & ~m0_ack;
  assign busy  = (state != IDLE);

endmodule
